// File: rtl/sd_read_scheduler.sv
// sd_read_scheduler: brings the SD card up through sd_init (bounded retries,
// per-attempt timeout), then shares sd_read block reads between NREQ
// requesters and returns each 32-bit result to its owner with a one-cycle ack.
//
// Build option: define SD_SCHED_FIXED_PRIO_EN for fixed priority (lowest
// requester index wins, no rotating pointer). Default is round-robin.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// RST_WAIT | both engines idle-checked (done low) before starting init
// INIT     | init_start held, waiting for init_done or attempt timeout
// INIT_GAP | init_start low, waiting for init_done low; retry or give up
// READY    | card up, arbitrating requesters
// READ     | read_start held for the granted owner, timeout running
// DONE     | ack to owner with fresh rd_data
// DONE_ERR | ack to owner with rd_err, then re-initialise the card
// READ_GAP | waiting for read_done low before the next grant
// FAULT    | init retries exhausted; only reset leaves
module sd_read_scheduler #(
  parameter int          NREQ         = 2,
  parameter logic [23:0] TIMEOUT      = 24'd1_000_000,
  parameter int          INIT_RETRIES = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NREQ-1:0]      req,
  input  logic [32*NREQ-1:0]   req_addr,
  output logic [NREQ-1:0]      ack,
  output logic [31:0]          rd_data,
  output logic                 rd_err,
  output logic                 ready,
  output logic                 fault,
  output logic                 spi_sel,
  output logic                 init_start,
  input  logic                 init_done,
  output logic                 read_start,
  output logic [31:0]          read_addr,
  input  logic                 read_done,
  input  logic [31:0]          read_data
);

  localparam int PTR_W = $clog2(NREQ);
  localparam int RTY_W = 8;
  localparam logic [PTR_W:0]   NREQ_P    = (PTR_W+1)'(NREQ);
  localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(NREQ - 1);
  localparam logic [RTY_W-1:0] RETRY_MAX = RTY_W'(INIT_RETRIES);

  localparam logic [3:0] ST_RST_WAIT = 4'd0;
  localparam logic [3:0] ST_INIT     = 4'd1;
  localparam logic [3:0] ST_INIT_GAP = 4'd2;
  localparam logic [3:0] ST_READY    = 4'd3;
  localparam logic [3:0] ST_READ     = 4'd4;
  localparam logic [3:0] ST_DONE     = 4'd5;
  localparam logic [3:0] ST_DONE_ERR = 4'd6;
  localparam logic [3:0] ST_READ_GAP = 4'd7;
  localparam logic [3:0] ST_FAULT    = 4'd8;

  logic [3:0]       state_q, state_d;
  logic [23:0]      timer_q;
  logic [RTY_W-1:0] retry_cnt_q, retry_cnt_d;
  logic [PTR_W-1:0] owner_q, owner_d;
  logic [31:0]      read_addr_q, read_addr_d;
  logic [31:0]      rd_data_q, rd_data_d;
  logic [PTR_W-1:0] rr_base;
  logic [PTR_W-1:0] rr_next;
  logic             gnt_valid;
  logic [PTR_W-1:0] gnt_idx;
  logic [PTR_W:0]   cand_sum;
  logic [PTR_W-1:0] cand;
  logic             timer_tc;

  assign timer_tc = (timer_q == TIMEOUT - 24'd1);
  assign rr_next  = (owner_q == LAST_IDX) ? '0 : owner_q + PTR_W'(1);

`ifdef SD_SCHED_FIXED_PRIO_EN
  assign rr_base = '0;
`else
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;

  // Rotating search origin: one past the most recently served owner.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (state_q == ST_DONE || state_q == ST_DONE_ERR) rr_ptr_d = rr_next;
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rr_ptr_q <= '0;
    else          rr_ptr_q <= rr_ptr_d;
  end

  assign rr_base = rr_ptr_q;
`endif

  // First requesting index searching upward from rr_base, wrapping.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    cand_sum  = '0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand_sum = {1'b0, rr_base} + (PTR_W+1)'(k);
      if (cand_sum >= NREQ_P) cand_sum = cand_sum - NREQ_P;
      cand = cand_sum[PTR_W-1:0];
      if (!gnt_valid && req[cand]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  // Sequencing: next state, retry count, grant latch and result capture.
  always_comb begin
    state_d     = state_q;
    retry_cnt_d = retry_cnt_q;
    owner_d     = owner_q;
    read_addr_d = read_addr_q;
    rd_data_d   = rd_data_q;
    case (state_q)
      ST_RST_WAIT: if (!init_done && !read_done) state_d = ST_INIT;
      ST_INIT: begin
        if (init_done) state_d = ST_READY;
        else if (timer_tc) begin
          state_d     = ST_INIT_GAP;
          retry_cnt_d = retry_cnt_q + RTY_W'(1);
        end
      end
      ST_INIT_GAP: begin
        if (!init_done) state_d = (retry_cnt_q == RETRY_MAX) ? ST_FAULT : ST_INIT;
      end
      ST_READY: begin
        if (gnt_valid) begin
          owner_d     = gnt_idx;
          read_addr_d = req_addr[32*gnt_idx +: 32];
          state_d     = ST_READ;
        end
      end
      ST_READ: begin
        if (read_done) begin
          rd_data_d = read_data;
          state_d   = ST_DONE;
        end else if (timer_tc) begin
          state_d = ST_DONE_ERR;
        end
      end
      ST_DONE:     state_d = ST_READ_GAP;
      ST_DONE_ERR: begin
        retry_cnt_d = '0;
        state_d     = ST_RST_WAIT;
      end
      ST_READ_GAP: if (!read_done) state_d = ST_READY;
      ST_FAULT:    state_d = ST_FAULT;
      default:     state_d = ST_RST_WAIT;
    endcase
  end

  // State and datapath registers; the timer restarts on every state entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_RST_WAIT;
      timer_q     <= '0;
      retry_cnt_q <= '0;
      owner_q     <= '0;
      read_addr_q <= '0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      retry_cnt_q <= retry_cnt_d;
      owner_q     <= owner_d;
      read_addr_q <= read_addr_d;
      rd_data_q   <= rd_data_d;
      if (state_d != state_q)                          timer_q <= '0;
      else if (state_q == ST_INIT || state_q == ST_READ) timer_q <= timer_q + 24'd1;
    end
  end

  // Ack pulse to the current owner on completion or abort.
  always_comb begin
    ack = '0;
    if (state_q == ST_DONE || state_q == ST_DONE_ERR) ack[owner_q] = 1'b1;
  end

  assign init_start = (state_q == ST_INIT);
  assign read_start = (state_q == ST_READ);
  assign ready      = (state_q == ST_READY) || (state_q == ST_READ) ||
                      (state_q == ST_DONE)  || (state_q == ST_READ_GAP);
  // sd_read keeps the bus through the error ack; it returns to sd_init only
  // once the re-init sequence begins.
  assign spi_sel    = ready || (state_q == ST_DONE_ERR);
  assign fault      = (state_q == ST_FAULT);
  assign rd_err     = (state_q == ST_DONE_ERR);
  assign rd_data    = rd_data_q;
  assign read_addr  = read_addr_q;

endmodule

// File: tb/tb_sd_read_scheduler.sv
module tb_sd_read_scheduler;
  localparam int          NREQ = 2;
  localparam logic [23:0] TO   = 24'd100;
  localparam int          RET  = 3;

  logic                clk = 1'b0;
  logic                reset_n = 1'b0;
  logic [NREQ-1:0]     req = '0;
  logic [32*NREQ-1:0]  req_addr = '0;
  logic [NREQ-1:0]     ack;
  logic [31:0]         rd_data;
  logic                rd_err, ready, fault, spi_sel, init_start, read_start;
  logic                init_done = 1'b0;
  logic [31:0]         read_addr;
  logic                read_done = 1'b0;
  logic [31:0]         read_data = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sd_read_scheduler #(.NREQ(NREQ), .TIMEOUT(TO), .INIT_RETRIES(RET)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_addr(req_addr), .ack(ack),
    .rd_data(rd_data), .rd_err(rd_err), .ready(ready), .fault(fault),
    .spi_sel(spi_sel), .init_start(init_start), .init_done(init_done),
    .read_start(read_start), .read_addr(read_addr), .read_done(read_done),
    .read_data(read_data)
  );

  task automatic test_reset();
    reset_n = 1'b0; req = '0; req_addr = '0; init_done = 0; read_done = 0; read_data = '0;
    repeat (3) @(negedge clk);
    checks++; if (init_start !== 1'b0) begin errors++; $display("FAIL rst_init_start got %b exp 0", init_start); end
    checks++; if (read_start !== 1'b0) begin errors++; $display("FAIL rst_read_start got %b exp 0", read_start); end
    checks++; if (ready !== 1'b0)      begin errors++; $display("FAIL rst_ready got %b exp 0", ready); end
    checks++; if (fault !== 1'b0)      begin errors++; $display("FAIL rst_fault got %b exp 0", fault); end
    checks++; if (spi_sel !== 1'b0)    begin errors++; $display("FAIL rst_spi_sel got %b exp 0", spi_sel); end
    checks++; if (ack !== '0)          begin errors++; $display("FAIL rst_ack got %b exp 0", ack); end
    checks++; if (rd_err !== 1'b0)     begin errors++; $display("FAIL rst_rd_err got %b exp 0", rd_err); end
    checks++; if (rd_data !== 32'h0)   begin errors++; $display("FAIL rst_rd_data got %h exp 0", rd_data); end
    checks++; if (read_addr !== 32'h0) begin errors++; $display("FAIL rst_read_addr got %h exp 0", read_addr); end
  endtask

  // init_done rises in the 5th init_start cycle; ready must follow one cycle later.
  task automatic test_init_ok();
    int cnt = 0, cyc = 0, done_at = -1;
    reset_n = 1'b1;
    while (ready !== 1'b1 && cyc < 50) begin
      @(negedge clk); cyc++;
      if (init_start === 1'b1) cnt++;
      if (cnt == 5 && done_at < 0) begin init_done = 1'b1; done_at = cyc; end
    end
    checks++; if (ready !== 1'b1)      begin errors++; $display("FAIL init_ok_ready got %b exp 1", ready); end
    checks++; if (spi_sel !== 1'b1)    begin errors++; $display("FAIL init_ok_spi_sel got %b exp 1", spi_sel); end
    checks++; if (init_start !== 1'b0) begin errors++; $display("FAIL init_ok_start_low got %b exp 0", init_start); end
    checks++; if (cnt != 5)            begin errors++; $display("FAIL init_ok_start_len got %0d exp 5", cnt); end
    checks++; if (cyc != done_at + 1)  begin errors++; $display("FAIL init_ok_latency got %0d exp %0d", cyc, done_at + 1); end
    init_done = 1'b0;
  endtask

  // Init never completes: RET attempts of TO cycles, each followed by a one-cycle gap.
  task automatic test_init_fault();
    int run = 0, pulses = 0, fault_at = -1, ready_seen = 0;
    reset_n = 1'b0; init_done = 0; read_done = 0; req = '0;
    @(negedge clk); reset_n = 1'b1;
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      if (init_start === 1'b1) run++;
      else if (run > 0) begin
        pulses++;
        checks++; if (run != int'(TO)) begin errors++; $display("FAIL fault_pulse_len got %0d exp %0d", run, TO); end
        run = 0;
      end
      if (fault === 1'b1 && fault_at < 0) fault_at = c;
      if (ready === 1'b1) ready_seen++;
    end
    checks++; if (pulses != RET)  begin errors++; $display("FAIL fault_pulses got %0d exp %0d", pulses, RET); end
    checks++; if (fault_at != RET * (int'(TO) + 1) + 1) begin errors++; $display("FAIL fault_time got %0d exp %0d", fault_at, RET * (int'(TO) + 1) + 1); end
    checks++; if (fault !== 1'b1) begin errors++; $display("FAIL fault_sticky got %b exp 1", fault); end
    checks++; if (ready_seen != 0) begin errors++; $display("FAIL fault_ready got %0d exp 0", ready_seen); end
    reset_n = 1'b0; #1;
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL fault_clear got %b exp 0", fault); end
  endtask

  task automatic bring_up();
    int cyc = 0;
    reset_n = 1'b0; init_done = 0; read_done = 0; req = '0;
    @(negedge clk); reset_n = 1'b1;
    while (ready !== 1'b1 && cyc < 40) begin
      @(negedge clk); cyc++;
      if (init_start === 1'b1) init_done = 1'b1;
    end
    init_done = 1'b0;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL bringup_ready got %b exp 1", ready); end
  endtask

  task automatic test_rr_directed();
    bring_up();
    req_addr = {32'h0000_0205, 32'h0000_0200}; req = 2'b11;
    @(negedge clk);
    checks++; if (read_start !== 1'b1)       begin errors++; $display("FAIL rr_start0 got %b exp 1", read_start); end
    checks++; if (read_addr !== 32'h200)     begin errors++; $display("FAIL rr_addr0 got %h exp 200", read_addr); end
    repeat (2) @(negedge clk);
    read_done = 1'b1; read_data = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++; if (ack !== 2'b01)             begin errors++; $display("FAIL rr_ack0 got %b exp 01", ack); end
    checks++; if (rd_data !== 32'hDEADBEEF)  begin errors++; $display("FAIL rr_data0 got %h exp deadbeef", rd_data); end
    checks++; if (rd_err !== 1'b0)           begin errors++; $display("FAIL rr_err0 got %b exp 0", rd_err); end
    checks++; if (read_start !== 1'b0)       begin errors++; $display("FAIL rr_start_drop got %b exp 0", read_start); end
    req[0] = 1'b0; read_done = 1'b0;
    @(negedge clk);
    checks++; if (ack !== 2'b00)             begin errors++; $display("FAIL rr_ack_pulse got %b exp 00", ack); end
    checks++; if (read_start !== 1'b0)       begin errors++; $display("FAIL rr_gap1 got %b exp 0", read_start); end
    @(negedge clk);
    checks++; if (read_start !== 1'b0)       begin errors++; $display("FAIL rr_gap2 got %b exp 0", read_start); end
    @(negedge clk);
    checks++; if (read_start !== 1'b1)       begin errors++; $display("FAIL rr_start1 got %b exp 1", read_start); end
    checks++; if (read_addr !== 32'h205)     begin errors++; $display("FAIL rr_addr1 got %h exp 205", read_addr); end
    @(negedge clk);
    read_done = 1'b1; read_data = 32'h1234_5678;
    @(negedge clk);
    checks++; if (ack !== 2'b10)             begin errors++; $display("FAIL rr_ack1 got %b exp 10", ack); end
    checks++; if (rd_data !== 32'h12345678)  begin errors++; $display("FAIL rr_data1 got %h exp 12345678", rd_data); end
    req = '0; read_done = 1'b0;
    @(negedge clk);
    checks++; if (rd_data !== 32'h12345678)  begin errors++; $display("FAIL rr_data_hold got %h exp 12345678", rd_data); end
  endtask

  // Read never completes: error ack in READ cycle TO+1, then re-init.
  task automatic test_read_timeout();
    int n = 0, rs = 0, seen = 0;
    @(negedge clk);
    req_addr[31:0] = 32'h300; req = 2'b01;
    while (ack === '0 && n < 200) begin
      @(negedge clk); n++;
      if (read_start === 1'b1) rs++;
    end
    checks++; if (n != int'(TO) + 1)        begin errors++; $display("FAIL to_ack_cycle got %0d exp %0d", n, int'(TO) + 1); end
    checks++; if (rs != int'(TO))           begin errors++; $display("FAIL to_start_len got %0d exp %0d", rs, TO); end
    checks++; if (ack !== 2'b01)            begin errors++; $display("FAIL to_ack got %b exp 01", ack); end
    checks++; if (rd_err !== 1'b1)          begin errors++; $display("FAIL to_rd_err got %b exp 1", rd_err); end
    checks++; if (rd_data !== 32'h12345678) begin errors++; $display("FAIL to_rd_data got %h exp 12345678", rd_data); end
    checks++; if (ready !== 1'b0)           begin errors++; $display("FAIL to_ready got %b exp 0", ready); end
    req = '0;
    for (int c = 0; c < 5 && seen == 0; c++) begin
      @(negedge clk);
      if (init_start === 1'b1) seen = 1;
    end
    checks++; if (seen != 1) begin errors++; $display("FAIL to_reinit got %0d exp 1", seen); end
    init_done = 1'b1;
    @(negedge clk);
    init_done = 1'b0;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL to_ready_again got %b exp 1", ready); end
  endtask

  task automatic test_reset_mid_read();
    int cyc = 0, ack_seen = 0;
    req_addr[63:32] = 32'h400; req = 2'b10;
    @(negedge clk);
    checks++; if (read_start !== 1'b1) begin errors++; $display("FAIL mid_start got %b exp 1", read_start); end
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0; #1;
    checks++; if (read_start !== 1'b0)   begin errors++; $display("FAIL mid_start_async got %b exp 0", read_start); end
    checks++; if (ready !== 1'b0)        begin errors++; $display("FAIL mid_ready got %b exp 0", ready); end
    checks++; if (spi_sel !== 1'b0)      begin errors++; $display("FAIL mid_spi_sel got %b exp 0", spi_sel); end
    checks++; if (read_addr !== 32'h0)   begin errors++; $display("FAIL mid_read_addr got %h exp 0", read_addr); end
    @(negedge clk); reset_n = 1'b1;
    while (ready !== 1'b1 && cyc < 40) begin
      @(negedge clk); cyc++;
      if (ack !== '0) ack_seen++;
      if (init_start === 1'b1) init_done = 1'b1;
    end
    init_done = 1'b0;
    checks++; if (ack_seen != 0) begin errors++; $display("FAIL mid_spurious_ack got %0d exp 0", ack_seen); end
    @(negedge clk);
    checks++; if (read_addr !== 32'h400) begin errors++; $display("FAIL mid_reserve_addr got %h exp 400", read_addr); end
    read_done = 1'b1; read_data = 32'hCAFE_0001;
    @(negedge clk);
    checks++; if (ack !== 2'b10)           begin errors++; $display("FAIL mid_ack got %b exp 10", ack); end
    checks++; if (rd_data !== 32'hCAFE0001) begin errors++; $display("FAIL mid_data got %h exp cafe0001", rd_data); end
    req = '0; read_done = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Random requesters against a queue-free arbitration model: the owner is the
  // first requester at or after (last owner + 1), and each result must come
  // back to that owner one cycle after the engine reports done.
  task automatic test_random();
    int ptr = 0, owner = -1, lat = 0, cnt = 0, hold_left = 0;
    int last_ack = -100, served = 0, idle_wait = 0, e;
    logic ack_due = 1'b0;
    logic [31:0] exp_data = '0, exp_addr = '0;
    logic [NREQ-1:0] exp_ack;
    bring_up();
    for (int cyc = 0; cyc < 700; cyc++) begin
      @(negedge clk);
      exp_ack = '0;
      if (ack_due) exp_ack[owner] = 1'b1;
      checks++; if (ack !== exp_ack) begin errors++; $display("FAIL rand_ack cyc=%0d got %b exp %b", cyc, ack, exp_ack); end
      checks++; if (ready !== 1'b1)  begin errors++; $display("FAIL rand_ready cyc=%0d got %b exp 1", cyc, ready); end
      if (read_start === 1'b1) begin
        checks++; if (read_done !== 1'b0) begin errors++; $display("FAIL rand_start_while_done cyc=%0d got %b exp 0", cyc, read_done); end
      end
      if (ack_due) begin
        checks++; if (rd_data !== exp_data) begin errors++; $display("FAIL rand_data cyc=%0d got %h exp %h", cyc, rd_data, exp_data); end
        checks++; if (rd_err !== 1'b0)      begin errors++; $display("FAIL rand_err cyc=%0d got %b exp 0", cyc, rd_err); end
        req[owner] = 1'b0;
        ptr = (owner + 1) % NREQ;
        last_ack = cyc; owner = -1; ack_due = 1'b0; served++;
        hold_left = $urandom_range(0, 2);
      end
      if (owner < 0 && read_done === 1'b1) begin
        if (hold_left == 0) read_done = 1'b0;
        else hold_left--;
      end
      if (owner < 0 && read_start === 1'b1) begin
        e = -1;
`ifdef SD_SCHED_FIXED_PRIO_EN
        for (int k = NREQ - 1; k >= 0; k--) if (req[k]) e = k;
`else
        for (int k = NREQ - 1; k >= 0; k--) if (req[(ptr + k) % NREQ]) e = (ptr + k) % NREQ;
`endif
        checks++;
        if (e < 0) begin errors++; $display("FAIL rand_grant_none cyc=%0d got start exp idle", cyc); e = 0; end
        owner = e; exp_addr = req_addr[32*e +: 32];
        checks++; if (cyc - last_ack < 3) begin errors++; $display("FAIL rand_regrant_gap cyc=%0d got %0d exp >=3", cyc, cyc - last_ack); end
        lat = $urandom_range(1, 6); cnt = 0; exp_data = $urandom;
        idle_wait = 0;
      end
      if (owner >= 0 && !ack_due) begin
        checks++; if (read_start !== 1'b1)   begin errors++; $display("FAIL rand_start_hold cyc=%0d got %b exp 1", cyc, read_start); end
        checks++; if (read_addr !== exp_addr) begin errors++; $display("FAIL rand_addr cyc=%0d got %h exp %h", cyc, read_addr, exp_addr); end
        cnt++;
        if (cnt == lat) begin read_done = 1'b1; read_data = exp_data; ack_due = 1'b1; end
      end
      if (owner < 0 && req != '0) idle_wait++;
      else idle_wait = 0;
      if (idle_wait > 12) begin
        checks++; errors++;
        $display("FAIL rand_grant_timeout cyc=%0d got no grant exp grant within 12", cyc);
        idle_wait = 0;
      end
      for (int i = 0; i < NREQ; i++) begin
        if (!req[i] && owner != i && $urandom_range(0, 2) == 0) begin
          req_addr[32*i +: 32] = ($urandom & 32'hFFFF_FFFC) | 32'(i);
          req[i] = 1'b1;
        end
      end
    end
    checks++; if (served < 20) begin errors++; $display("FAIL rand_served got %0d exp >=20", served); end
  endtask

  initial begin
    test_reset();
    test_init_ok();
    test_init_fault();
    test_rr_directed();
    test_read_timeout();
    test_reset_mid_read();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
